// File: rtl/seven_seg_scanner_if.sv
// Display-driver bundle: BCD time digits and blink controls in, common-anode pin drive out.
interface seven_seg_scanner_if;
  logic [1:0] H1;
  logic [3:0] H2;
  logic [2:0] M1;
  logic [3:0] M2;
  logic       adjust;
  logic [3:0] blink_mask;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output H1, H2, M1, M2, adjust, blink_mask,
    input  anode, seg, dp
  );

  modport slave (
    input  H1, H2, M1, M2, adjust, blink_mask,
    output anode, seg, dp
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit common-anode 7-segment scanner with blank slots and blink.
// Optional LEADING_ZERO_BLANK_EN: hides a zero hours-tens digit outside time-set mode.
module seven_seg_scanner #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 50000000
) (
  input  logic                 clk,
  input  logic                 rst,
  seven_seg_scanner_if.slave   bus
);

  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam int unsigned BW = $clog2(BLINK_DIV);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]    digit_idx_q, digit_idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          refresh_wrap;
  logic          blink_wrap;
  logic [3:0]    sel_val;
  logic [3:0]    sel_max;
  logic [3:0]    sel_onehot;
  logic          hidden;

  // Active-low segment pattern; anything above the digit's legal range shows a dash.
  function automatic logic [6:0] decode(input logic [3:0] v, input logic [3:0] max_v);
    logic [6:0] s;
    if (v > max_v) begin
      s = SEG_DASH;
    end else begin
      case (v)
        4'd0:    s = 7'b1000000;
        4'd1:    s = 7'b1111001;
        4'd2:    s = 7'b0100100;
        4'd3:    s = 7'b0110000;
        4'd4:    s = 7'b0011001;
        4'd5:    s = 7'b0010010;
        4'd6:    s = 7'b0000010;
        4'd7:    s = 7'b1111000;
        4'd8:    s = 7'b0000000;
        4'd9:    s = 7'b0010000;
        default: s = SEG_DASH;
      endcase
    end
    return s;
  endfunction

  always_comb begin
    refresh_cnt_d = refresh_cnt_q;
    digit_idx_d   = digit_idx_q;
    blink_cnt_d   = '0;
    blink_phase_d = 1'b1;
    anode_d       = 4'hF;
    seg_d         = SEG_BLANK;
    dp_d          = 1'b1;
    sel_val       = 4'd0;
    sel_max       = 4'd9;

    refresh_wrap  = (refresh_cnt_q == RW'(REFRESH_DIV - 1));
    refresh_cnt_d = refresh_wrap ? '0 : refresh_cnt_q + RW'(1);
    digit_idx_d   = refresh_wrap ? digit_idx_q + 2'd1 : digit_idx_q;

    // Blink timebase only runs in time-set mode; leaving it re-arms a visible first phase.
    blink_wrap = (blink_cnt_q == BW'(BLINK_DIV - 1));
    if (bus.adjust) begin
      blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BW'(1);
      blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;
    end

    case (digit_idx_q)
      2'd0:    begin sel_val = 4'(bus.H1); sel_max = 4'd2; end
      2'd1:    begin sel_val = bus.H2;     sel_max = 4'd9; end
      2'd2:    begin sel_val = 4'(bus.M1); sel_max = 4'd5; end
      default: begin sel_val = bus.M2;     sel_max = 4'd9; end
    endcase

    sel_onehot = 4'b1000 >> digit_idx_q;
    hidden     = bus.adjust && !blink_phase_q && ((sel_onehot & bus.blink_mask) != 4'd0);
`ifdef LEADING_ZERO_BLANK_EN
    if ((digit_idx_q == 2'd0) && (bus.H1 == 2'd0) && !bus.adjust) begin
      hidden = 1'b1;
    end
`endif

    // First cycle of every slot stays dark to avoid ghosting between digits.
    if (refresh_cnt_q != '0) begin
      anode_d = hidden ? 4'hF : ~sel_onehot;
      seg_d   = decode(sel_val, sel_max);
      dp_d    = !((digit_idx_q == 2'd1) && !hidden);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt_q <= '0;
      digit_idx_q   <= 2'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      anode_q       <= 4'hF;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      digit_idx_q   <= digit_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      anode_q       <= anode_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign bus.anode = anode_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Time-multiplexed 4-digit 7-segment display driver. It consumes the BCD time digits produced by the clock's time-keeping counters: H1, H2, M1, M2.
- Scans one digit per refresh slot, blanks between slots to suppress ghosting, and blinks selected digits while the user adjusts time.
- Sits between the time/alarm datapath and the board's common-anode display pins.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot (100 MHz -> 1 kHz per digit). Minimum 2.
- BLINK_DIV, 50000000: clk cycles per blink phase (0.5 s at 100 MHz). Minimum 2.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- H1  input  2  hours tens digit, valid 0..2
- H2  input  4  hours units digit, valid 0..9
- M1  input  3  minutes tens digit, valid 0..5
- M2  input  4  minutes units digit, valid 0..9
- adjust  input  1  1 = time-set mode, enables blinking
- blink_mask  input  4  per-digit blink enable {H1,H2,M1,M2} = bits [3:0]
- anode  output  4  digit enables, active-low; [3]=H1, [2]=H2, [1]=M1, [0]=M2
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point / colon, active-low

Behaviour:
- Reset (rst=0, async):
  - refresh_cnt=0, digit_idx=0, blink_cnt=0, blink_phase=1 (visible).
  - anode=4'b1111, seg=7'b1111111, dp=1.
- Refresh counter:
  - refresh_cnt counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit_idx advances 0->1->2->3->0. Index 0=H1, 1=H2, 2=M1, 3=M2.
- Outputs are registered: each edge loads anode/seg/dp from the pre-edge refresh_cnt, digit_idx, blink_phase and inputs. Latency is 1 cycle.
- Inter-digit blank: when refresh_cnt==0, load anode=1111, seg=1111111, dp=1. Each slot is therefore 1 blank cycle plus REFRESH_DIV-1 lit cycles.
- Lit cycle:
  - The anode bit for the selected digit is 0; all other bits are 1.
  - seg is the decoded value of the selected input.
- Decode table (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Out-of-range value (H1>2, M1>5, H2/M2>9): show dash, seg=0111111. The value is never wrapped or clamped.
- dp: 0 while H2 is lit (colon), 1 otherwise.
- Blink:
  - While adjust=1, blink_cnt counts 0..BLINK_DIV-1. On wrap, blink_phase toggles.
  - A digit whose blink_mask bit is 1 has its anode held at 1 while blink_phase=0. seg is still driven.
  - dp blinks with H2 only if blink_mask[2]=1.
- adjust=0: blink_cnt is held at 0, blink_phase is held at 1, and blink_mask is ignored.
- Rising edge of adjust: digits are visible for the first full BLINK_DIV cycles.
- Simultaneous events:
  - Digit inputs changing mid-slot show on the next edge (no sampling per slot).
  - A refresh wrap and a blink wrap on the same edge are independent; both take effect.
- Reset asserted mid-slot blanks the outputs immediately (asynchronously). After release, the scan restarts at H1 with a blank cycle.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when H1==0 and adjust=0, the H1 slot keeps anode=1111 for the whole slot (e.g., 09:45 displays " 9:45"). When adjust=1, H1 zero is shown normally so the user sees the digit being set.
- Undefined: H1 is always displayed, including 0.

Test Plan (REFRESH_DIV=4, BLINK_DIV=16):
1. Release reset with H1=1, H2=2, M1=3, M2=4, adjust=0 -> at edges 1..16:
   - Edge 1: blank.
   - Edges 2-4: anode=0111, seg=1111001.
   - Edge 5: blank.
   - Edges 6-8: anode=1011, seg=0100100, dp=0.
   - Then anode=1101 with seg=0110000, then anode=1110 with seg=0011001, then wrap to H1.
2. Hold H2=4'hC, M1=3'd7 -> their slots show seg=0111111; H1=3 -> dash in the H1 slot.
3. adjust=1, blink_mask=4'b0011:
   - First 16 cycles: all digits lit.
   - Next 16 cycles: the M1/M2 slots keep anode=1111; H1/H2 still lit.
   - Drop adjust: all digits lit on the next slot.
4. Assert rst mid-slot while anode=1011 -> anode=1111 and seg=1111111 with no clock edge. After release, the first lit slot is H1.
5. Change M2 from 4 to 7 while the M2 slot is lit -> seg=1111000 one edge later, anode unchanged.
6. With LEADING_ZERO_BLANK_EN, H1=0, adjust=0 -> the H1 slot stays anode=1111 for all 4 cycles. With adjust=1 it shows seg=1000000. Without the macro it always shows 1000000.
